ps2_link_ctrl: RTL and testbench

Host-side PS/2 link sequencer. It arbitrates the bidirectional PS/2 bus between device-to-host frames and host-to-device commands.
- Arms the byte receiver via rx_wait.
- Detects incoming start bits so commands are not issued mid-frame.
- Runs the full host-to-device protocol: clock inhibit, request-to-send, bit shifting, parity, stop, ack.
- Supervises everything with timeouts.

It sits between the pin-level edge detector / open-drain pads and the byte receiver.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_link_ctrl_if.sv | 14 +
 rtl/ps2_watchdog.sv | 35 +++
 rtl/ps2_link_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ps2_link_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types, default timing and helpers for the host-side PS/2 link sequencer.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_BUSY,
        INHIBIT,
        RTS,
        TX_BITS,
        TX_STOP,
        TX_ACK
    } link_state_t;

    localparam int unsigned BYTE_W                   = 8;
    localparam int unsigned FRAME_BITS               = 9;  // data byte plus parity
    localparam int unsigned IDX_W                    = 4;
    localparam int unsigned DEF_INHIBIT_CYCLES       = 5000;
    localparam int unsigned DEF_START_TIMEOUT_CYCLES = 750000;
    localparam int unsigned DEF_BIT_TIMEOUT_CYCLES   = 100000;

    function automatic logic odd_parity(input logic [BYTE_W-1:0] b);
        return ~^b;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_link_ctrl_if.sv
// Command handshake between a command source and the PS/2 link sequencer.
interface ps2_link_ctrl_if;
    import ps2_pkg::*;

    logic              cmd_valid;
    logic [BYTE_W-1:0] cmd_byte;
    logic              cmd_ready;
    logic              cmd_done;
    logic              cmd_error;

    modport master (output cmd_valid, cmd_byte, input cmd_ready, cmd_done, cmd_error);
    modport slave  (input cmd_valid, cmd_byte, output cmd_ready, cmd_done, cmd_error);

endinterface

// File: rtl/ps2_watchdog.sv
// Loadable saturating down-counter; expired is high once the loaded limit has elapsed.
module ps2_watchdog #(
    parameter int unsigned W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count;
    logic [W-1:0] count_nxt;

    // Loading limit-1 makes expired rise exactly limit cycles after the clear
    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = limit - W'(1);
        end else if (count != '0) begin
            count_nxt = count - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            count   <= count_nxt;
            expired <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/ps2_link_ctrl.sv
// Host-side PS/2 link sequencer: arbitrates device frames against host commands
// and runs the host-to-device protocol under watchdog supervision.
module ps2_link_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES       = DEF_INHIBIT_CYCLES,
    parameter int unsigned START_TIMEOUT_CYCLES = DEF_START_TIMEOUT_CYCLES,
    parameter int unsigned BIT_TIMEOUT_CYCLES   = DEF_BIT_TIMEOUT_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ps2_clk_posedge,
    input  logic            ps2_clk_negedge,
    input  logic            ps2_data,
    ps2_link_ctrl_if.slave  cmd,
    output logic            rx_wait,
    input  logic            rx_data_en,
    output logic            rx_frame_err,
    output logic            busy,
    output logic            ps2_clk_oe,
    output logic            ps2_data_oe
);

    localparam int unsigned WD_W =
        $clog2(max3(START_TIMEOUT_CYCLES, INHIBIT_CYCLES, BIT_TIMEOUT_CYCLES) + 1);

    link_state_t           state, state_nxt;
    logic [FRAME_BITS-1:0] tx_frame, tx_frame_nxt;
    logic [IDX_W-1:0]      bit_idx, bit_idx_nxt;
    logic                  clk_oe_nxt, data_oe_nxt;
    logic                  done_q, done_nxt, error_q, error_nxt, frame_err_nxt;
    logic                  start_bit, any_edge;
    logic                  wd_clear, wd_expired;
    logic [WD_W-1:0]       wd_limit;

    assign start_bit     = ps2_clk_posedge & ~ps2_data;
    assign any_edge      = ps2_clk_posedge | ps2_clk_negedge;
    assign cmd.cmd_ready = (state == IDLE) & ~start_bit;
    assign cmd.cmd_done  = done_q;
    assign cmd.cmd_error = error_q;

    always_comb begin
        state_nxt     = state;
        tx_frame_nxt  = tx_frame;
        bit_idx_nxt   = bit_idx;
        clk_oe_nxt    = ps2_clk_oe;
        data_oe_nxt   = ps2_data_oe;
        done_nxt      = 1'b0;
        error_nxt     = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                if (start_bit) begin
                    state_nxt = RX_BUSY;
                end else if (cmd.cmd_valid) begin
                    state_nxt    = INHIBIT;
                    tx_frame_nxt = {odd_parity(cmd.cmd_byte), cmd.cmd_byte};
                    clk_oe_nxt   = 1'b1;
                end
            end
            RX_BUSY: begin
                if (rx_data_en) begin
                    state_nxt = IDLE;
                end else if (wd_expired & ~any_edge) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            INHIBIT: begin
                // Release clock and present the start bit on the same edge
                if (wd_expired) begin
                    state_nxt   = RTS;
                    clk_oe_nxt  = 1'b0;
                    data_oe_nxt = 1'b1;
                end
            end
            RTS: begin
                if (ps2_clk_negedge) begin
                    data_oe_nxt = ~tx_frame[0];
                    bit_idx_nxt = IDX_W'(1);
                    state_nxt   = TX_BITS;
                end else if (wd_expired) begin
                    state_nxt = IDLE;
                end
            end
            TX_BITS: begin
                if (ps2_clk_negedge) begin
                    if (bit_idx == IDX_W'(FRAME_BITS)) begin
                        data_oe_nxt = 1'b0;
                        state_nxt   = TX_STOP;
                    end else begin
                        data_oe_nxt = ~tx_frame[bit_idx];
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                    end
                end else if (wd_expired & ~any_edge) begin
                    state_nxt = IDLE;
                end
            end
            TX_STOP: begin
                if (ps2_clk_negedge) begin
                    state_nxt = TX_ACK;
                end else if (wd_expired & ~any_edge) begin
                    state_nxt = IDLE;
                end
            end
            TX_ACK: begin
                if (ps2_clk_posedge) begin
                    done_nxt  = 1'b1;
                    error_nxt = ps2_data;
                    state_nxt = IDLE;
                end else if (wd_expired & ~any_edge) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Any timeout out of a TX state is an error exit with both lines released
        if ((state inside {RTS, TX_BITS, TX_STOP, TX_ACK}) && state_nxt == IDLE && !done_nxt) begin
            clk_oe_nxt  = 1'b0;
            data_oe_nxt = 1'b0;
            done_nxt    = 1'b1;
            error_nxt   = 1'b1;
        end
    end

    // Device clock edges are ignored while we are holding the clock low ourselves
    always_comb begin
        wd_clear = (state_nxt != state) | (any_edge & (state != INHIBIT));
        wd_limit = WD_W'(BIT_TIMEOUT_CYCLES);
        case (state_nxt)
            INHIBIT: wd_limit = WD_W'(INHIBIT_CYCLES);
            RTS:     wd_limit = WD_W'(START_TIMEOUT_CYCLES);
            default: wd_limit = WD_W'(BIT_TIMEOUT_CYCLES);
        endcase
    end

    ps2_watchdog #(.W(WD_W)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .limit   (wd_limit),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tx_frame     <= '0;
            bit_idx      <= '0;
            ps2_clk_oe   <= 1'b0;
            ps2_data_oe  <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            rx_frame_err <= 1'b0;
            busy         <= 1'b0;
            rx_wait      <= 1'b1;
        end else begin
            state        <= state_nxt;
            tx_frame     <= tx_frame_nxt;
            bit_idx      <= bit_idx_nxt;
            ps2_clk_oe   <= clk_oe_nxt;
            ps2_data_oe  <= data_oe_nxt;
            done_q       <= done_nxt;
            error_q      <= error_nxt;
            rx_frame_err <= frame_err_nxt;
            busy         <= (state_nxt != IDLE);
            rx_wait      <= (state_nxt == IDLE) | (state_nxt == RX_BUSY);
        end
    end

endmodule

// File: tb/tb_ps2_link_ctrl.sv
// Self-checking bench for ps2_link_ctrl: device-side PS/2 model plus a
// scoreboard of expected command outcomes popped on every cmd_done pulse.
module tb_ps2_link_ctrl;

    localparam int unsigned INH = 40;
    localparam int unsigned STO = 300;
    localparam int unsigned BTO = 200;

    logic clk             = 1'b0;
    logic reset           = 1'b1;
    logic ps2_clk_posedge = 1'b0;
    logic ps2_clk_negedge = 1'b0;
    logic ps2_data        = 1'b1;
    logic rx_data_en      = 1'b0;
    logic rx_wait, rx_frame_err, busy, ps2_clk_oe, ps2_data_oe;

    ps2_link_ctrl_if bus ();

    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    logic exp_q[$];
    logic last_done   = 1'b0;
    logic mon_oe      = 1'b0;
    logic mon_both    = 1'b0;
    logic mon_ready   = 1'b0;
    logic mon_idle    = 1'b0;
    logic mon_rxw_low = 1'b0;

    ps2_link_ctrl #(
        .INHIBIT_CYCLES       (INH),
        .START_TIMEOUT_CYCLES (STO),
        .BIT_TIMEOUT_CYCLES   (BTO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ps2_clk_posedge (ps2_clk_posedge),
        .ps2_clk_negedge (ps2_clk_negedge),
        .ps2_data        (ps2_data),
        .cmd             (bus.slave),
        .rx_wait         (rx_wait),
        .rx_data_en      (rx_data_en),
        .rx_frame_err    (rx_frame_err),
        .busy            (busy),
        .ps2_clk_oe      (ps2_clk_oe),
        .ps2_data_oe     (ps2_data_oe)
    );

    always #5 clk = ~clk;

    // One cycle; samples outputs on the falling clock and scores any cmd_done.
    task automatic tick();
        logic e;
        @(negedge clk);
        last_done   = bus.cmd_done;
        mon_oe      = mon_oe | ps2_clk_oe | ps2_data_oe;
        mon_both    = mon_both | (ps2_clk_oe & ps2_data_oe);
        mon_ready   = mon_ready | bus.cmd_ready;
        mon_idle    = mon_idle | ~busy;
        mon_rxw_low = mon_rxw_low | ~rx_wait;
        if (bus.cmd_done === 1'b1) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cmd_done: got cmd_error=%0b, required no pulse", bus.cmd_error);
            end else begin
                e = exp_q.pop_front();
                if (bus.cmd_error !== e) begin
                    errors++;
                    $display("FAIL cmd_error: got %0b required %0b", bus.cmd_error, e);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_mon();
        mon_oe = 1'b0; mon_both = 1'b0; mon_ready = 1'b0; mon_idle = 1'b0; mon_rxw_low = 1'b0;
    endtask

    task automatic clk_edge(input bit neg);
        if (neg) ps2_clk_negedge = 1'b1;
        else     ps2_clk_posedge = 1'b1;
        tick();
        ps2_clk_negedge = 1'b0;
        ps2_clk_posedge = 1'b0;
    endtask

    task automatic issue_cmd(input logic [7:0] b, input logic exp_err);
        bus.cmd_valid = 1'b1;
        bus.cmd_byte  = b;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_idle: got %0b required 1", bus.cmd_ready);
        end
        exp_q.push_back(exp_err);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_start_bit();
        int n = 0;
        while (ps2_data_oe !== 1'b1 && n < int'(INH) + 10) begin tick(); n++; end
    endtask

    task automatic wait_done(input int bound, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin tick(); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: cmd_done absent after %0d cycles, required within bound", name, bound);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        #1;
        checks++;
        if ({rx_wait, busy, ps2_clk_oe, ps2_data_oe, bus.cmd_done, bus.cmd_error, rx_frame_err, bus.cmd_ready}
            !== 8'b1000_0001) begin
            errors++;
            $display("FAIL reset_state: got %b required 10000001",
                     {rx_wait, busy, ps2_clk_oe, ps2_data_oe, bus.cmd_done, bus.cmd_error, rx_frame_err, bus.cmd_ready});
        end
        idle(2);
    endtask

    task automatic test_idle_rx(input logic [7:0] b);
        logic [9:0] frame;
        frame    = {1'b1, ~^b, b};
        ps2_data = 1'b0;
        clk_edge(1'b0);
        checks++;
        if ({busy, rx_wait, bus.cmd_ready} !== 3'b110) begin
            errors++;
            $display("FAIL rx_start: got busy/rx_wait/ready=%b required 110", {busy, rx_wait, bus.cmd_ready});
        end
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            clk_edge(1'b1);
            idle(2);
            ps2_data = frame[i];
            clk_edge(1'b0);
            idle(2);
        end
        ps2_data = 1'b1;
        checks++;
        if ({mon_oe, mon_ready, mon_idle, mon_rxw_low} !== 4'b0000) begin
            errors++;
            $display("FAIL rx_frame_flags: got oe/ready/idle/rxwait_low=%b required 0000",
                     {mon_oe, mon_ready, mon_idle, mon_rxw_low});
        end
        rx_data_en = 1'b1;
        tick();
        rx_data_en = 1'b0;
        checks++;
        if ({busy, rx_wait} !== 2'b01) begin
            errors++;
            $display("FAIL rx_end: got busy/rx_wait=%b required 01", {busy, rx_wait});
        end
        idle(2);
    endtask

    task automatic test_cmd(input logic [7:0] b, input logic nack, input string name);
        logic [8:0] frame;
        logic       exp_oe;
        int         n;
        frame = {~^b, b};
        clear_mon();
        issue_cmd(b, nack);
        bus.cmd_byte = ~b;
        n = 0;
        while (ps2_clk_oe === 1'b1 && n < int'(INH) + 10) begin n++; tick(); end
        checks++;
        if (n != int'(INH)) begin
            errors++;
            $display("FAIL %s_inhibit_len: got %0d cycles required %0d", name, n, INH);
        end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, rx_wait} !== 3'b010) begin
            errors++;
            $display("FAIL %s_rts: got clk_oe/data_oe/rx_wait=%b required 010", name, {ps2_clk_oe, ps2_data_oe, rx_wait});
        end
        for (int k = 0; k < 11; k++) begin
            clk_edge(1'b1);
            exp_oe = (k < 9) ? ~frame[k] : 1'b0;
            checks++;
            if (ps2_data_oe !== exp_oe) begin
                errors++;
                $display("FAIL %s_data_oe[%0d]: got %0b required %0b", name, k, ps2_data_oe, exp_oe);
            end
            idle(3);
            if (k == 10) ps2_data = nack;
            clk_edge(1'b0);
            ps2_data = 1'b1;
            idle(3);
        end
        wait_done(5, {name, "_done"});
        checks++;
        if ({busy, ps2_clk_oe, ps2_data_oe, mon_both} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_end: got busy/clk_oe/data_oe/both_seen=%b required 0000",
                     name, {busy, ps2_clk_oe, ps2_data_oe, mon_both});
        end
    endtask

    task automatic test_start_timeout(input logic [7:0] b);
        int n;
        issue_cmd(b, 1'b1);
        wait_start_bit();
        n = 0;
        last_done = 1'b0;
        while (!last_done && n < int'(STO) + 10) begin tick(); n++; end
        checks++;
        if (n != int'(STO)) begin
            errors++;
            $display("FAIL start_timeout_len: got %0d cycles required %0d", n, STO);
        end
        checks++;
        if ({busy, ps2_clk_oe, ps2_data_oe} !== 3'b000) begin
            errors++;
            $display("FAIL start_timeout_lines: got busy/clk_oe/data_oe=%b required 000", {busy, ps2_clk_oe, ps2_data_oe});
        end
        wait_done(2, "start_timeout_done");
        idle(2);
    endtask

    task automatic test_collision();
        bus.cmd_valid   = 1'b1;
        bus.cmd_byte    = 8'hAB;
        ps2_data        = 1'b0;
        ps2_clk_posedge = 1'b1;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL collision_ready: got %0b required 0", bus.cmd_ready);
        end
        tick();
        ps2_clk_posedge = 1'b0;
        ps2_data        = 1'b1;
        clear_mon();
        idle(6);
        checks++;
        if ({busy, mon_idle, mon_oe, mon_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL collision_rx_busy: got busy/idle_seen/oe_seen/ready_seen=%b required 1000",
                     {busy, mon_idle, mon_oe, mon_ready});
        end
        rx_data_en = 1'b1;
        tick();
        rx_data_en = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL collision_rx_end: got busy=%0b required 0", busy);
        end
        issue_cmd(8'hAB, 1'b1);
        checks++;
        if ({busy, ps2_clk_oe, rx_wait} !== 3'b110) begin
            errors++;
            $display("FAIL collision_accept: got busy/clk_oe/rx_wait=%b required 110", {busy, ps2_clk_oe, rx_wait});
        end
        wait_done(int'(INH + STO) + 20, "collision_done");
        idle(2);
    endtask

    task automatic test_rx_timeout();
        int n;
        ps2_data = 1'b0;
        clk_edge(1'b0);
        ps2_data = 1'b1;
        n = 0;
        while (rx_frame_err !== 1'b1 && n < int'(BTO) + 10) begin tick(); n++; end
        checks++;
        if (n != int'(BTO) || busy !== 1'b0) begin
            errors++;
            $display("FAIL rx_timeout: got %0d cycles busy=%0b required %0d cycles busy=0", n, busy, BTO);
        end
        tick();
        checks++;
        if (rx_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL rx_frame_err_pulse: got %0b required 0", rx_frame_err);
        end
    endtask

    task automatic test_reset_mid(input logic [7:0] b);
        int done_before;
        issue_cmd(b, 1'b0);
        wait_start_bit();
        for (int k = 0; k < 4; k++) begin
            clk_edge(1'b1);
            checks++;
            if (ps2_data_oe !== ~b[k]) begin
                errors++;
                $display("FAIL reset_mid_bit[%0d]: got %0b required %0b", k, ps2_data_oe, ~b[k]);
            end
            idle(2);
        end
        done_before = done_cnt;
        reset = 1'b1;
        tick();
        exp_q.delete();
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, busy, rx_wait, bus.cmd_done} !== 5'b00010) begin
            errors++;
            $display("FAIL reset_mid_state: got clk_oe/data_oe/busy/rx_wait/done=%b required 00010",
                     {ps2_clk_oe, ps2_data_oe, busy, rx_wait, bus.cmd_done});
        end
        reset = 1'b0;
        idle(20);
        checks++;
        if (done_cnt != done_before) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d pulses required 0", done_cnt - done_before);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_byte  = 8'h00;
        test_reset();
        test_idle_rx(8'h1C);
        test_cmd(8'hED, 1'b0, "cmd_ed");
        test_cmd(8'hF4, 1'b1, "cmd_f4_nack");
        test_start_timeout(8'hFF);
        test_collision();
        test_rx_timeout();
        test_reset_mid(8'h5A);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
